rs_enc_stream: RTL
==================

RS_ENC_STREAM -- requirements
Module: rs_enc_stream

Interface
REQ-001 SHALL have parameter K, default 64: message bytes per codeword; fixed, matches the encoder input width.
REQ-002 SHALL have parameter NPAR, default 4: parity bytes per codeword; fixed, matches the encoder output width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_data  input  8  input message byte.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  block accepts s_data; registered.
REQ-008 SHALL have port m_data  output  8  output codeword byte.
REQ-009 SHALL have port m_valid  output  1  m_data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-011 SHALL have port m_last  output  1  high with the final (68th) codeword byte.
REQ-012 SHALL have port enc_msg  output  K x 8  message array to the RS encoder.
REQ-013 SHALL have port enc_valid  output  1  one-cycle encoder launch strobe.
REQ-014 SHALL have port enc_parity  input  NPAR x 8  parity array from the encoder.
REQ-015 SHALL have port enc_parity_valid  input  1  enc_parity valid; encoder latency is 1 cycle.

Function
REQ-016 SHALL implement FSM states FILL, LAUNCH, WAIT, SEND_MSG, SEND_PAR.
REQ-017 SHALL be in FILL: s_ready=1; each s_valid&s_ready beat writes s_data to buffer[wr_idx]; wr_idx increments 0..63; the beat at wr_idx=63 moves to LAUNCH and s_ready drops in the next cycle.
REQ-018 SHALL be in LAUNCH: enc_valid=1 for exactly one cycle; then move to WAIT.
REQ-019 SHALL be in WAIT: on enc_parity_valid, capture enc_parity into the parity register and move to SEND_MSG; enc_parity_valid outside WAIT is ignored.
REQ-020 SHALL drive enc_msg[n] = buffer[n] continuously; buffer byte n is the nth accepted input byte.
REQ-021 SHALL be in SEND_MSG: m_valid=1, m_data=buffer[rd_idx]; each m_valid&m_ready beat increments rd_idx; the beat at 63 moves to SEND_PAR.
REQ-022 SHALL be in SEND_PAR: m_data=parity[p], p=0..3; m_last=1 when p=3; the m_last beat returns to FILL with wr_idx, rd_idx, p cleared.
REQ-023 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0; m_valid SHALL NOT drop before the handshake.
REQ-024 SHALL meet this latency: last input beat at cycle t gives enc_valid at t+1, parity capture at t+2, first m_valid at t+3 with m_ready held high.
REQ-025 SHALL emit a codeword as exactly 68 beats: 64 message bytes in input order, then 4 parity bytes.
REQ-026 SHALL keep s_ready=0 outside FILL; input is never accepted while a codeword is in flight.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state=FILL, indices=0, s_ready=0, m_valid=0, m_last=0, enc_valid=0, m_data=0.
REQ-028 SHALL raise s_ready in the first clk edge after rst_n deasserts.
REQ-029 SHALL discard a partial frame or in-flight codeword on reset; buffer contents need not be cleared.

Configuration
REQ-030 SHALL, when RS_ENC_STREAM_STATS_EN is defined, add output frame_cnt (16 bit, reset 0), incremented on each m_last handshake and wrapping 65535->0.
REQ-031 SHALL, when RS_ENC_STREAM_STATS_EN is undefined, have no frame_cnt port and no counter logic.

Structure
REQ-032 SHALL take K, NPAR, SYM_W=8, N=K+NPAR and the FSM state enum from shared package rs_pkg.
REQ-033 SHALL place the 64x8 buffer, write port and read mux in sub-module rs_frame_buf.

Verification
REQ-034 SHALL cover: bytes 0..63 streamed, m_ready=1, encoder model -> 68 beats equal to 0..63 followed by model parity, m_last only on beat 68, latency per REQ-024.
REQ-035 SHALL cover: all-zero message -> 64 zero bytes followed by parity 0,0,0,0.
REQ-036 SHALL cover: random m_ready (50%) -> m_data/m_last stable across stalls and byte order unchanged.
REQ-037 SHALL cover: s_valid held high through a whole codeword -> s_ready=0 from LAUNCH to the m_last beat; byte 64 is accepted only after returning to FILL.
REQ-038 SHALL cover: rst_n pulsed low during SEND_MSG at rd_idx=20 -> m_valid=0 immediately; the next 64 bytes form a clean new codeword.
REQ-039 SHALL cover, with RS_ENC_STREAM_STATS_EN: 3 codewords -> frame_cnt=3; preload 65535, one codeword -> frame_cnt=0.

Source files
------------

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared RS codeword geometry and encoder-framing FSM states
// Purpose: K message bytes + NPAR parity bytes per codeword, symbol width, state enum.
// Ports: none (package).
package rs_pkg;
    localparam int K     = 64;
    localparam int NPAR  = 4;
    localparam int SYM_W = 8;
    localparam int N     = K + NPAR;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_LAUNCH,
        ST_WAIT,
        ST_SEND_MSG,
        ST_SEND_PAR
    } rs_state_e;
endpackage

// File: rtl/rs_enc_stream_if.sv
// rtl/rs_enc_stream_if.sv - byte-stream handshake bundle for rs_enc_stream
// Purpose: input message stream (s_*) and output codeword stream (m_*).
// Ports (signals): s_data, s_valid, s_ready, m_data, m_valid, m_ready, m_last.
//   slave  modport: the framing block (consumes s_*, produces m_*).
//   master modport: the environment around it.
interface rs_enc_stream_if;
    import rs_pkg::*;

    logic [SYM_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [SYM_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/rs_frame_buf.sv
// rtl/rs_frame_buf.sv - message byte buffer with one write port and one read mux
// Purpose: holds the DEPTH message bytes of the codeword being built/sent.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata read mux;
//        mem exposes every byte in parallel (byte n at mem[n]).
// Contents are not reset; a new frame always overwrites every byte before use.
module rs_frame_buf
    import rs_pkg::*;
#(
    parameter int DEPTH = K,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [AW-1:0]               waddr,
    input  logic [SYM_W-1:0]            wdata,
    input  logic [AW-1:0]               raddr,
    output logic [SYM_W-1:0]            rdata,
    output logic [DEPTH-1:0][SYM_W-1:0] mem
);
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rs_enc_stream.sv
// rtl/rs_enc_stream.sv - frames a byte stream into RS codewords around an external encoder
// Purpose: collect K bytes, launch the encoder, capture its parity, then stream
//          K message bytes followed by NPAR parity bytes (m_last on the final one).
// Ports: clk, rst_n (async, active-low); bus (slave modport: s_data/s_valid/s_ready,
//        m_data/m_valid/m_ready/m_last); enc_msg, enc_valid to the encoder;
//        enc_parity, enc_parity_valid from the encoder (1-cycle latency);
//        frame_cnt (16-bit completed-codeword count) only when RS_ENC_STREAM_STATS_EN is defined.
module rs_enc_stream #(
    parameter int K    = rs_pkg::K,
    parameter int NPAR = rs_pkg::NPAR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    rs_enc_stream_if.slave                    bus,
    output logic [K-1:0][rs_pkg::SYM_W-1:0]    enc_msg,
    output logic                              enc_valid,
    input  logic [NPAR-1:0][rs_pkg::SYM_W-1:0] enc_parity,
    input  logic                              enc_parity_valid
`ifdef RS_ENC_STREAM_STATS_EN
    ,
    output logic [15:0]                       frame_cnt
`endif
);
    import rs_pkg::*;

    localparam int AW = $clog2(K);
    localparam int PW = (NPAR > 1) ? $clog2(NPAR) : 1;
    localparam logic [AW-1:0] LAST_MSG = AW'(K - 1);
    localparam logic [PW-1:0] LAST_PAR = PW'(NPAR - 1);

    rs_state_e                    state_q, state_d;
    logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
    logic [PW-1:0]                p_q, p_d;
    logic [NPAR-1:0][SYM_W-1:0]   par_q;
    logic                         par_ld;
    logic                         buf_we;
    logic                         s_ready_q;
    logic [SYM_W-1:0]             rd_data;

    rs_frame_buf #(.DEPTH(K)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_q),
        .wdata (bus.s_data),
        .raddr (rd_q),
        .rdata (rd_data),
        .mem   (enc_msg)
    );

    assign bus.s_ready = s_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            wr_q      <= '0;
            rd_q      <= '0;
            p_q       <= '0;
            par_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            p_q       <= p_d;
            // s_ready is a flop, so it follows the state we are entering.
            s_ready_q <= (state_d == ST_FILL);
            if (par_ld) begin
                par_q <= enc_parity;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        p_d         = p_q;
        par_ld      = 1'b0;
        buf_we      = 1'b0;
        enc_valid   = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        bus.m_data  = '0;
        case (state_q)
            ST_FILL: begin
                if (bus.s_valid && s_ready_q) begin
                    buf_we = 1'b1;
                    wr_d   = wr_q + AW'(1);
                    if (wr_q == LAST_MSG) begin
                        wr_d    = '0;
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                enc_valid = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Parity strobes arriving in any other state are dropped.
                if (enc_parity_valid) begin
                    par_ld  = 1'b1;
                    state_d = ST_SEND_MSG;
                end
            end
            ST_SEND_MSG: begin
                bus.m_valid = 1'b1;
                bus.m_data  = rd_data;
                if (bus.m_ready) begin
                    rd_d = rd_q + AW'(1);
                    if (rd_q == LAST_MSG) begin
                        rd_d    = '0;
                        state_d = ST_SEND_PAR;
                    end
                end
            end
            ST_SEND_PAR: begin
                bus.m_valid = 1'b1;
                bus.m_data  = par_q[p_q];
                bus.m_last  = (p_q == LAST_PAR);
                if (bus.m_ready) begin
                    p_d = p_q + PW'(1);
                    if (p_q == LAST_PAR) begin
                        p_d     = '0;
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

`ifdef RS_ENC_STREAM_STATS_EN
    logic frame_done;
    assign frame_done = (state_q == ST_SEND_PAR) && (p_q == LAST_PAR) && bus.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif
endmodule
